vrename_ctrl: RTL and testbench
===============================

VRENAME_CTRL -- requirements
Module: vrename_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_ENTRIES, default 32, number of architectural vector registers.
REQ-002 SHALL have parameter PHYS_REGS, default 64, number of physical vector registers; legal only when PHYS_REGS > TOTAL_ENTRIES.
REQ-003 SHALL derive AW=$clog2(TOTAL_ENTRIES) and PW=$clog2(PHYS_REGS) as localparams.
REQ-004 One clock; reset is asynchronous and active-low: clk_i  in  1  clock; rstn_i  in  1  async active-low reset.
REQ-005 rn_valid_i  in  1  rename request valid.
REQ-006 rn_arch_i  in  AW  architectural destination register to rename.
REQ-007 rn_ready_o  out  1  controller can accept a rename this cycle.
REQ-008 rn_phys_o  out  PW  physical register allocated (valid when rn_ready_o).
REQ-009 rel_valid_i  in  1  commit releases a physical register.
REQ-010 rel_phys_i  in  PW  physical register being freed.
REQ-011 recfg_i  in  1  pulse: rebuild identity mapping and free list.
REQ-012 rat_we_o  out  1, rat_waddr_o  out  AW, rat_wdata_o  out  PW: drives the RAT write port.
REQ-013 busy_o  out  1  high while rebuilding.
REQ-014 free_cnt_o  out  PW+1  current free-list occupancy.
REQ-015 ovf_o  out  1  sticky: release arrived while free list full.

Function
REQ-016 Free list SHALL be a circular FIFO of PHYS_REGS-TOTAL_ENTRIES entries of PW bits, with head/tail pointers wrapping at capacity and a count register.
REQ-017 FSM SHALL have states RUN and REINIT.
REQ-018 In RUN, rn_ready_o SHALL equal (count != 0); rn_phys_o SHALL equal the entry at head.
REQ-019 Rename fire = rn_valid_i && rn_ready_o; on fire, in the same cycle, rat_we_o=1, rat_waddr_o=rn_arch_i, rat_wdata_o=head entry; head advances at the next edge (zero-cycle latency to the RAT write).
REQ-020 In RUN, a release with count < capacity SHALL push rel_phys_i at tail at the next edge.
REQ-021 Simultaneous fire and release in RUN SHALL pop and push in the same cycle; count is unchanged.
REQ-022 A release when empty SHALL NOT be bypassed to rn_phys_o: rn_ready_o stays 0 that cycle.
REQ-023 A release when count == capacity and no fire that cycle SHALL be dropped and set ovf_o.
REQ-024 recfg_i in RUN SHALL move the FSM to REINIT at the next edge with index idx=0; a rename in the same cycle as recfg_i is still honoured.
REQ-025 In REINIT, busy_o=1 and rn_ready_o=0; releases SHALL be ignored.
REQ-026 For each REINIT cycle idx:
- idx < TOTAL_ENTRIES: rat_we_o=1, waddr=idx, wdata=idx.
- idx >= TOTAL_ENTRIES: free-list entry [idx-TOTAL_ENTRIES] = idx.
REQ-027 REINIT SHALL last exactly PHYS_REGS cycles; it then returns to RUN with head=tail=0, count=capacity, and ovf_o=0.
REQ-028 recfg_i asserted during REINIT SHALL restart idx at 0.
REQ-029 rat_we_o SHALL be 0 in any cycle with neither a fire nor a REINIT write.

Reset
REQ-030 On rstn_i low, the block SHALL enter:
- State: RUN; head=tail=0; count=capacity.
- Free list: entry[k]=TOTAL_ENTRIES+k.
- Outputs: ovf_o=0, busy_o=0, rat_we_o=0.
REQ-031 This reset state SHALL match the RAT's reset identity mapping, so no REINIT is needed after reset.
REQ-032 Reset asserted mid-REINIT SHALL abort immediately to the reset state.

Structure
REQ-033 The rename FSM state enum SHALL be placed in cellrv32_package; the capacity is a localparam.
REQ-034 The free list SHALL be one sub-module, vfreelist_fifo (push/pop/count, with a parallel init write port used by REINIT).

Verification
REQ-035 Reset; check free_cnt_o=32, rn_phys_o=32; rename arch 5 -> rat_we_o=1, waddr=5, wdata=32 in the same cycle; next cycle rn_phys_o=33.
REQ-036 32 back-to-back renames -> free_cnt_o=0 and rn_ready_o=0; then release phys 7 with rn_valid_i held -> no fire that cycle; next cycle fire with wdata=7.
REQ-037 With count=10, fire and release (phys 3) in the same cycle -> count stays 10; phys 3 appears at head after the wrap.
REQ-038 With the list full, release phys 9 -> ovf_o=1 and count stays 32; ovf_o holds until reset or REINIT completes.
REQ-039 recfg_i pulse -> busy_o=1 for 64 cycles; RAT writes (i,i) for i=0..31; then RUN with count=32 and rn_phys_o=32; recfg_i at REINIT cycle 20 -> restarts, 64 more cycles.
REQ-040 Assert rstn_i low during REINIT cycle 10 -> immediate reset state, busy_o=0, count=32.

Source files
------------

// File: rtl/cellrv32_package.sv
// Shared types for the vector rename controller.
package cellrv32_package;

  // Rename controller FSM: normal operation or rebuilding identity map + free list.
  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StReinit = 1'b1
  } vrn_state_e;

endpackage

// File: rtl/vfreelist_fifo.sv
// Circular free list of physical register indices with a parallel init write port.
module vfreelist_fifo #(
  parameter int unsigned Depth    = 32,
  parameter int unsigned Width    = 6,
  parameter int unsigned InitBase = 32,
  localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             fill_i,
  input  logic             init_we_i,
  input  logic [PtrW-1:0]  init_addr_i,
  input  logic [Width-1:0] init_data_i,
  output logic [Width-1:0] head_data_o,
  output logic [Width:0]   count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [Width:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy update; fill (end of rebuild) overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{Width{1'b0}}, push_i} - {{Width{1'b0}}, pop_i};
    if (pop_i)  head_d = ptr_inc(head_q);
    if (push_i) tail_d = ptr_inc(tail_q);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    if (fill_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = (Width+1)'(Depth);
    end
  end

  // Pointer registers; reset leaves the list full.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= (Width+1)'(Depth);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage; reset contents match the RAT identity map (entry k holds InitBase+k).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < int'(Depth); k++) begin
        mem_q[k] <= Width'(InitBase + k);
      end
    end else if (init_we_i) begin
      mem_q[init_addr_i] <= init_data_i;
    end else if (push_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/vrename_ctrl.sv
// Vector register rename controller: allocates physical registers from a free
// list, drives the RAT write port, and can rebuild the identity mapping.
module vrename_ctrl
  import cellrv32_package::*;
#(
  parameter int unsigned TOTAL_ENTRIES = 32,
  parameter int unsigned PHYS_REGS     = 64,
  localparam int unsigned AW           = $clog2(TOTAL_ENTRIES),
  localparam int unsigned PW           = $clog2(PHYS_REGS)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          rn_valid_i,
  input  logic [AW-1:0] rn_arch_i,
  output logic          rn_ready_o,
  output logic [PW-1:0] rn_phys_o,
  input  logic          rel_valid_i,
  input  logic [PW-1:0] rel_phys_i,
  input  logic          recfg_i,
  output logic          rat_we_o,
  output logic [AW-1:0] rat_waddr_o,
  output logic [PW-1:0] rat_wdata_o,
  output logic          busy_o,
  output logic [PW:0]   free_cnt_o,
  output logic          ovf_o
);

  localparam int unsigned Cap  = PHYS_REGS - TOTAL_ENTRIES;
  localparam int unsigned PtrW = (Cap > 1) ? $clog2(Cap) : 1;

  vrn_state_e    state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic          run, fire, full, push, ovf_set;
  logic          flush, fill, init_we, idx_is_rat;
  logic [PtrW-1:0] init_addr;
  logic [PW:0]   free_cnt;
  logic [PW-1:0] head_data;

  // Handshake, release acceptance and RAT write-port muxing.
  always_comb begin
    run        = (state_q == StRun);
    rn_ready_o = run && (free_cnt != '0);
    fire       = rn_valid_i && rn_ready_o;
    full       = (free_cnt == (PW+1)'(Cap));
    // A full list can still take a release when a rename pops in the same cycle.
    push       = run && rel_valid_i && (!full || fire);
    ovf_set    = run && rel_valid_i && full && !fire;
    idx_is_rat = (idx_q < PW'(TOTAL_ENTRIES));
    init_we    = !run && !idx_is_rat;
    init_addr  = PtrW'(idx_q - PW'(TOTAL_ENTRIES));
    rat_we_o    = 1'b0;
    rat_waddr_o = '0;
    rat_wdata_o = '0;
    if (fire) begin
      rat_we_o    = 1'b1;
      rat_waddr_o = rn_arch_i;
      rat_wdata_o = head_data;
    end else if (!run && idx_is_rat) begin
      rat_we_o    = 1'b1;
      rat_waddr_o = AW'(idx_q);
      rat_wdata_o = idx_q;
    end
  end

  // FSM next state: rebuild walks idx over every physical register once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    flush   = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ovf_set) ovf_d = 1'b1;
        if (recfg_i) begin
          state_d = StReinit;
          idx_d   = '0;
          flush   = 1'b1;
        end
      end
      StReinit: begin
        if (recfg_i) begin
          idx_d = '0;
        end else if (idx_q == PW'(PHYS_REGS - 1)) begin
          state_d = StRun;
          idx_d   = '0;
          ovf_d   = 1'b0;
          fill    = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM state, rebuild index and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StRun;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  vfreelist_fifo #(
    .Depth    (Cap),
    .Width    (PW),
    .InitBase (TOTAL_ENTRIES)
  ) u_freelist (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_data_i (rel_phys_i),
    .pop_i       (fire),
    .flush_i     (flush),
    .fill_i      (fill),
    .init_we_i   (init_we),
    .init_addr_i (init_addr),
    .init_data_i (idx_q),
    .head_data_o (head_data),
    .count_o     (free_cnt)
  );

  assign rn_phys_o  = head_data;
  assign free_cnt_o = free_cnt;
  assign busy_o     = !run;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_vrename_ctrl.sv
// Directed bench for vrename_ctrl (32 architectural, 64 physical registers).
module tb_vrename_ctrl;

  logic       clk;
  logic       rstn;
  logic       rn_valid;
  logic [4:0] rn_arch;
  logic       rn_ready;
  logic [5:0] rn_phys;
  logic       rel_valid;
  logic [5:0] rel_phys;
  logic       recfg;
  logic       rat_we;
  logic [4:0] rat_waddr;
  logic [5:0] rat_wdata;
  logic       busy;
  logic [6:0] free_cnt;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  vrename_ctrl #(
    .TOTAL_ENTRIES (32),
    .PHYS_REGS     (64)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rn_valid_i  (rn_valid),
    .rn_arch_i   (rn_arch),
    .rn_ready_o  (rn_ready),
    .rn_phys_o   (rn_phys),
    .rel_valid_i (rel_valid),
    .rel_phys_i  (rel_phys),
    .recfg_i     (recfg),
    .rat_we_o    (rat_we),
    .rat_waddr_o (rat_waddr),
    .rat_wdata_o (rat_wdata),
    .busy_o      (busy),
    .free_cnt_o  (free_cnt),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and land just after the following falling edge.
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL reset_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd32) begin errors++; $display("FAIL reset_phys: got %0d want 32", rn_phys); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", rat_we); end
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", rn_ready); end
    tick;
    rstn = 1'b1;
    tick;
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL post_reset_cnt: got %0d want 32", free_cnt); end
  endtask

  task automatic test_rename;
    rn_valid = 1'b1; rn_arch = 5'd5; #1;
    checks++; if (rat_we !== 1'b1) begin errors++; $display("FAIL rn_we: got %0b want 1", rat_we); end
    checks++; if (rat_waddr !== 5'd5) begin errors++; $display("FAIL rn_waddr: got %0d want 5", rat_waddr); end
    checks++; if (rat_wdata !== 6'd32) begin errors++; $display("FAIL rn_wdata: got %0d want 32", rat_wdata); end
    tick;
    rn_valid = 1'b0; #1;
    checks++; if (rn_phys !== 6'd33) begin errors++; $display("FAIL rn_next_phys: got %0d want 33", rn_phys); end
    checks++; if (free_cnt !== 7'd31) begin errors++; $display("FAIL rn_cnt: got %0d want 31", free_cnt); end
    checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL rn_idle_we: got %0b want 0", rat_we); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 31; i++) begin
      rn_valid = 1'b1; rn_arch = 5'(i); #1;
      if (i == 30) begin
        checks++; if (rat_wdata !== 6'd63) begin errors++; $display("FAIL drain_last: got %0d want 63", rat_wdata); end
      end
      tick;
    end
    rn_arch = 5'd9; #1;
    checks++; if (free_cnt !== 7'd0) begin errors++; $display("FAIL drain_cnt: got %0d want 0", free_cnt); end
    checks++; if (rn_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %0b want 0", rn_ready); end
    checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL drain_we: got %0b want 0", rat_we); end
    rel_valid = 1'b1; rel_phys = 6'd7; #1;
    checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL nobypass_we: got %0b want 0", rat_we); end
    checks++; if (rn_ready !== 1'b0) begin errors++; $display("FAIL nobypass_ready: got %0b want 0", rn_ready); end
    tick;
    rel_valid = 1'b0; #1;
    checks++; if (rat_we !== 1'b1) begin errors++; $display("FAIL refill_we: got %0b want 1", rat_we); end
    checks++; if (rat_wdata !== 6'd7) begin errors++; $display("FAIL refill_wdata: got %0d want 7", rat_wdata); end
    checks++; if (rat_waddr !== 5'd9) begin errors++; $display("FAIL refill_waddr: got %0d want 9", rat_waddr); end
    tick;
    rn_valid = 1'b0; #1;
    checks++; if (free_cnt !== 7'd0) begin errors++; $display("FAIL refill_cnt: got %0d want 0", free_cnt); end
  endtask

  task automatic test_simul;
    for (int i = 0; i < 10; i++) begin
      rel_valid = 1'b1; rel_phys = 6'(40 + i);
      tick;
    end
    rel_valid = 1'b0; #1;
    checks++; if (free_cnt !== 7'd10) begin errors++; $display("FAIL simul_pre_cnt: got %0d want 10", free_cnt); end
    checks++; if (rn_phys !== 6'd40) begin errors++; $display("FAIL simul_pre_head: got %0d want 40", rn_phys); end
    rn_valid = 1'b1; rn_arch = 5'd2; rel_valid = 1'b1; rel_phys = 6'd3; #1;
    checks++; if (rat_wdata !== 6'd40) begin errors++; $display("FAIL simul_wdata: got %0d want 40", rat_wdata); end
    tick;
    rn_valid = 1'b0; rel_valid = 1'b0; #1;
    checks++; if (free_cnt !== 7'd10) begin errors++; $display("FAIL simul_cnt: got %0d want 10", free_cnt); end
    checks++; if (rn_phys !== 6'd41) begin errors++; $display("FAIL simul_head: got %0d want 41", rn_phys); end
    for (int i = 0; i < 9; i++) begin
      rn_valid = 1'b1;
      tick;
    end
    rn_valid = 1'b0; #1;
    checks++; if (rn_phys !== 6'd3) begin errors++; $display("FAIL simul_tail_phys: got %0d want 3", rn_phys); end
    checks++; if (free_cnt !== 7'd1) begin errors++; $display("FAIL simul_tail_cnt: got %0d want 1", free_cnt); end
  endtask

  task automatic test_overflow;
    rstn = 1'b0;
    tick;
    rstn = 1'b1; #1;
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL ovf_pre_cnt: got %0d want 32", free_cnt); end
    rel_valid = 1'b1; rel_phys = 6'd9;
    tick;
    rel_valid = 1'b0; #1;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", ovf); end
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL ovf_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd32) begin errors++; $display("FAIL ovf_head: got %0d want 32", rn_phys); end
    tick; tick; tick;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
    // Full list with a rename in the same cycle: release is accepted.
    rn_valid = 1'b1; rn_arch = 5'd1; rel_valid = 1'b1; rel_phys = 6'd9;
    tick;
    rn_valid = 1'b0; rel_valid = 1'b0; #1;
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL full_swap_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd33) begin errors++; $display("FAIL full_swap_head: got %0d want 33", rn_phys); end
  endtask

  task automatic test_recfg;
    recfg = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL recfg_pre_busy: got %0b want 0", busy); end
    tick;
    recfg = 1'b0; rel_valid = 1'b1; rel_phys = 6'd5;
    for (int i = 0; i < 64; i++) begin
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reinit_busy[%0d]: got %0b want 1", i, busy); end
      checks++; if (rn_ready !== 1'b0) begin errors++; $display("FAIL reinit_ready[%0d]: got %0b want 0", i, rn_ready); end
      if (i < 32) begin
        checks++; if (rat_we !== 1'b1 || rat_waddr !== 5'(i) || rat_wdata !== 6'(i)) begin
          errors++; $display("FAIL reinit_rat[%0d]: got we=%0b a=%0d d=%0d want we=1 a=%0d d=%0d", i, rat_we, rat_waddr, rat_wdata, i, i);
        end
      end else begin
        checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL reinit_nowe[%0d]: got %0b want 0", i, rat_we); end
      end
      if (i == 63) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL reinit_ovf_hold: got %0b want 1", ovf); end
      end
      tick;
    end
    rel_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL recfg_done_busy: got %0b want 0", busy); end
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL recfg_done_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd32) begin errors++; $display("FAIL recfg_done_phys: got %0d want 32", rn_phys); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL recfg_done_ovf: got %0b want 0", ovf); end
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL recfg_done_ready: got %0b want 1", rn_ready); end
  endtask

  task automatic test_restart;
    int n;
    recfg = 1'b1; rn_valid = 1'b1; rn_arch = 5'd3; #1;
    checks++; if (rat_we !== 1'b1 || rat_waddr !== 5'd3 || rat_wdata !== 6'd32) begin
      errors++; $display("FAIL recfg_rename: got we=%0b a=%0d d=%0d want we=1 a=3 d=32", rat_we, rat_waddr, rat_wdata);
    end
    tick;
    recfg = 1'b0; rn_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    checks++; if (rat_waddr !== 5'd20) begin errors++; $display("FAIL restart_idx20: got %0d want 20", rat_waddr); end
    recfg = 1'b1;
    tick;
    recfg = 1'b0; #1;
    checks++; if (rat_we !== 1'b1 || rat_waddr !== 5'd0) begin
      errors++; $display("FAIL restart_idx0: got we=%0b a=%0d want we=1 a=0", rat_we, rat_waddr);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL restart_len: got %0d want 64", n); end
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL restart_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd32) begin errors++; $display("FAIL restart_phys: got %0d want 32", rn_phys); end
  endtask

  task automatic test_reset_mid;
    recfg = 1'b1;
    tick;
    recfg = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    checks++; if (rat_waddr !== 5'd10) begin errors++; $display("FAIL mid_idx10: got %0d want 10", rat_waddr); end
    rstn = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
    checks++; if (free_cnt !== 7'd32) begin errors++; $display("FAIL mid_cnt: got %0d want 32", free_cnt); end
    checks++; if (rn_phys !== 6'd32) begin errors++; $display("FAIL mid_phys: got %0d want 32", rn_phys); end
    checks++; if (rat_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", rat_we); end
    tick;
    rstn = 1'b1;
    tick;
    rn_valid = 1'b1; rn_arch = 5'd1; #1;
    checks++; if (rat_we !== 1'b1 || rat_wdata !== 6'd32) begin
      errors++; $display("FAIL mid_rename: got we=%0b d=%0d want we=1 d=32", rat_we, rat_wdata);
    end
    tick;
    rn_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0;
    rn_valid = 1'b0; rn_arch = '0;
    rel_valid = 1'b0; rel_phys = '0;
    recfg = 1'b0;
    #12;
    test_reset;
    test_rename;
    test_drain;
    test_simul;
    test_overflow;
    test_recfg;
    test_restart;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
